// File: rtl/cmp_pkg.sv
// Shared types for the sumu4 comparator and its consumers.
// Provides the FSM state enum, operand width, flag struct and a reference compare.
package cmp_pkg;

    localparam int unsigned CMP_W = 8;

    typedef enum logic [0:0] {
        ACCUM,
        HOLD
    } state_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_flags_t;

    function automatic cmp_flags_t cmp_ref(input logic [CMP_W-1:0] a,
                                           input logic [CMP_W-1:0] b);
        cmp_flags_t f;
        f.gt = (a > b);
        f.lt = (a < b);
        f.eq = (a == b);
        return f;
    endfunction

    function automatic logic is_onehot(input cmp_flags_t f);
        return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
    endfunction

endpackage

// File: rtl/cmp_frame_stats_if.sv
// Sample stream in and frame summary out for cmp_frame_stats.
// The master side feeds samples and takes summaries; the slave side is the block.
interface cmp_frame_stats_if
    import cmp_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 16
);

    localparam int unsigned CW = $clog2(FRAME_LEN + 1);

    logic             in_valid;
    logic             in_ready;
    logic [CMP_W-1:0] x;
    logic [CMP_W-1:0] y;
    logic             xgy;
    logic             xsy;
    logic             xey;

    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    gt_cnt;
    logic [CW-1:0]    lt_cnt;
    logic [CW-1:0]    eq_cnt;
    logic [CMP_W-1:0] x_max;

    modport master (
        output in_valid, x, y, xgy, xsy, xey, out_ready,
        input  in_ready, out_valid, gt_cnt, lt_cnt, eq_cnt, x_max
    );

    modport slave (
        input  in_valid, x, y, xgy, xsy, xey, out_ready,
        output in_ready, out_valid, gt_cnt, lt_cnt, eq_cnt, x_max
    );

endinterface

// File: rtl/cmp_flag_check.sv
// Combinational consistency check of comparator flags against the operands.
// bad is high when the flags are not one-hot or disagree with a local recompute.
module cmp_flag_check
    import cmp_pkg::*;
(
    input  logic [CMP_W-1:0] x,
    input  logic [CMP_W-1:0] y,
    input  cmp_flags_t       flags,
    output logic             bad
);

    cmp_flags_t ref_flags;
    logic       not_onehot;
    logic       mismatch;

    assign ref_flags  = cmp_ref(x, y);
    assign not_onehot = !is_onehot(flags);
    assign mismatch   = (flags != ref_flags);
    assign bad        = not_onehot || mismatch;

endmodule

// File: rtl/cmp_frame_stats.sv
// Frame statistics over the sumu4 comparator stream: gt/lt/eq counts and max x per frame.
// Define CMP_FRAME_CHECK_EN to add the sticky flag-consistency err output.
module cmp_frame_stats
    import cmp_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 16
) (
    input logic               clk,
    input logic               rst,
    cmp_frame_stats_if.slave  bus
`ifdef CMP_FRAME_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int unsigned CW = $clog2(FRAME_LEN + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    gt_q, gt_d;
    logic [CW-1:0]    lt_q, lt_d;
    logic [CW-1:0]    eq_q, eq_d;
    logic [CW-1:0]    smp_q, smp_d;
    logic [CMP_W-1:0] xmax_q, xmax_d;
    logic             accept;
    logic             last;

    assign accept = bus.in_valid && (state_q == ACCUM);
    assign last   = (smp_q == CW'(FRAME_LEN - 1));

    always_comb begin
        state_d = state_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        smp_d   = smp_q;
        xmax_d  = xmax_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    gt_d  = gt_q + CW'(bus.xgy);
                    lt_d  = lt_q + CW'(bus.xsy);
                    eq_d  = eq_q + CW'(bus.xey);
                    smp_d = smp_q + CW'(1);
                    // First sample of a frame loads x outright.
                    if ((smp_q == '0) || (bus.x > xmax_q)) begin
                        xmax_d = bus.x;
                    end
                    if (last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = ACCUM;
                    gt_d    = '0;
                    lt_d    = '0;
                    eq_d    = '0;
                    smp_d   = '0;
                    xmax_d  = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            gt_q    <= '0;
            lt_q    <= '0;
            eq_q    <= '0;
            smp_q   <= '0;
            xmax_q  <= '0;
        end else begin
            state_q <= state_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            smp_q   <= smp_d;
            xmax_q  <= xmax_d;
        end
    end

    // Handshake outputs come from state alone, never from in_valid/out_ready.
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.gt_cnt    = gt_q;
    assign bus.lt_cnt    = lt_q;
    assign bus.eq_cnt    = eq_q;
    assign bus.x_max     = xmax_q;

`ifdef CMP_FRAME_CHECK_EN
    cmp_flags_t flags;
    logic       flag_bad;

    assign flags = {bus.xgy, bus.xsy, bus.xey};

    cmp_flag_check u_check (
        .x     (bus.x),
        .y     (bus.y),
        .flags (flags),
        .bad   (flag_bad)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept && flag_bad) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cmp_frame_stats.sv
// Directed bench for cmp_frame_stats: table of 4-sample frames plus hand-written corner sequences.
// Covers FRAME_LEN of 4, 16 and 1; the err checks build only with CMP_FRAME_CHECK_EN.
module tb_cmp_frame_stats;
    import cmp_pkg::*;

    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] L = 3'b010;
    localparam logic [2:0] E = 3'b001;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] f;  // {xgy, xsy, xey}
    } smp_t;

    typedef struct packed {
        smp_t [3:0] s;
        logic [7:0] gt;
        logic [7:0] lt;
        logic [7:0] eq;
        logic [7:0] xm;
    } frame_t;

    logic   clk;
    logic   rst;
    int     total;
    int     bad;
    frame_t frames [5];

    cmp_frame_stats_if #(.FRAME_LEN(4))  i4 ();
    cmp_frame_stats_if #(.FRAME_LEN(16)) i16 ();
    cmp_frame_stats_if #(.FRAME_LEN(1))  i1 ();

`ifdef CMP_FRAME_CHECK_EN
    logic err4, err16, err1;
`endif

    cmp_frame_stats #(.FRAME_LEN(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (i4)
`ifdef CMP_FRAME_CHECK_EN
        ,
        .err (err4)
`endif
    );

    cmp_frame_stats #(.FRAME_LEN(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (i16)
`ifdef CMP_FRAME_CHECK_EN
        ,
        .err (err16)
`endif
    );

    cmp_frame_stats #(.FRAME_LEN(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (i1)
`ifdef CMP_FRAME_CHECK_EN
        ,
        .err (err1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic smp_t mk(input int x, input int y, input logic [2:0] f);
        smp_t s;
        s.x = 8'(x);
        s.y = 8'(y);
        s.f = f;
        return s;
    endfunction

    task automatic set_frame(input int i, input smp_t a, input smp_t b, input smp_t c,
                             input smp_t d, input int g, input int l, input int e, input int m);
        frames[i].s[0] = a;
        frames[i].s[1] = b;
        frames[i].s[2] = c;
        frames[i].s[3] = d;
        frames[i].gt   = 8'(g);
        frames[i].lt   = 8'(l);
        frames[i].eq   = 8'(e);
        frames[i].xm   = 8'(m);
    endtask

    task automatic drive4(input smp_t s);
        i4.in_valid = 1'b1;
        i4.x        = s.x;
        i4.y        = s.y;
        {i4.xgy, i4.xsy, i4.xey} = s.f;
    endtask

    task automatic chk4_counts(input string nm, input int g, input int l, input int e,
                               input int m);
        chk({nm, ".gt"}, 32'(i4.gt_cnt), 32'(g));
        chk({nm, ".lt"}, 32'(i4.lt_cnt), 32'(l));
        chk({nm, ".eq"}, 32'(i4.eq_cnt), 32'(e));
        chk({nm, ".xmax"}, 32'(i4.x_max), 32'(m));
    endtask

    // Feeds one table frame back-to-back; with bp set the summary is left pending in HOLD.
    task automatic run_frame(input int f, input bit bp);
        i4.out_ready = !bp;
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("f%0d.in_ready_s%0d", f, s), 32'(i4.in_ready), 1);
            drive4(frames[f].s[s]);
            step();
        end
        i4.in_valid = 1'b0;
        chk($sformatf("f%0d.out_valid", f), 32'(i4.out_valid), 1);
        chk($sformatf("f%0d.in_ready_hold", f), 32'(i4.in_ready), 0);
        chk4_counts($sformatf("f%0d", f), int'(frames[f].gt), int'(frames[f].lt),
                    int'(frames[f].eq), int'(frames[f].xm));
        if (!bp) begin
            step();
            chk($sformatf("f%0d.out_valid_after", f), 32'(i4.out_valid), 0);
            chk($sformatf("f%0d.in_ready_after", f), 32'(i4.in_ready), 1);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        set_frame(0, mk(5, 3, G), mk(2, 7, L), mk(4, 4, E), mk(9, 1, G), 2, 1, 1, 9);
        set_frame(1, mk(0, 0, E), mk(255, 0, G), mk(128, 200, L), mk(127, 127, E), 1, 1, 2, 255);
        // Malformed flags: none, gt+lt, all three; counts follow flags as given.
        set_frame(2, mk(10, 20, 3'b000), mk(30, 20, 3'b110), mk(7, 7, 3'b111), mk(1, 2, L),
                  2, 3, 1, 30);
        set_frame(3, mk(3, 200, L), mk(200, 3, G), mk(199, 199, E), mk(100, 50, G), 2, 1, 1, 200);
        set_frame(4, mk(0, 255, L), mk(0, 255, L), mk(0, 255, L), mk(0, 255, L), 0, 4, 0, 0);

        i4.in_valid = 1'b0;  i4.x = '0;  i4.y = '0;  i4.xgy = 1'b0;  i4.xsy = 1'b0;
        i4.xey = 1'b0;       i4.out_ready = 1'b1;
        i16.in_valid = 1'b0; i16.x = '0; i16.y = '0; i16.xgy = 1'b0; i16.xsy = 1'b0;
        i16.xey = 1'b0;      i16.out_ready = 1'b1;
        i1.in_valid = 1'b0;  i1.x = '0;  i1.y = '0;  i1.xgy = 1'b0;  i1.xsy = 1'b0;
        i1.xey = 1'b0;       i1.out_ready = 1'b1;

        rst = 1'b1;
        step();
        step();
        chk("rst.in_ready", 32'(i4.in_ready), 1);
        chk("rst.out_valid", 32'(i4.out_valid), 0);
        chk4_counts("rst", 0, 0, 0, 0);
        chk("rst16.in_ready", 32'(i16.in_ready), 1);
        chk("rst1.out_valid", 32'(i1.out_valid), 0);
`ifdef CMP_FRAME_CHECK_EN
        chk("rst.err", 32'(err4), 0);
`endif
        rst = 1'b0;

        for (int f = 0; f < 4; f++) begin
            run_frame(f, 1'b0);
        end

        // Back-pressure: summary frozen, HOLD-time samples ignored, take cycle accepts nothing.
        run_frame(0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            drive4(mk(255, 0, G));
            step();
            chk($sformatf("bp.out_valid_c%0d", c), 32'(i4.out_valid), 1);
            chk($sformatf("bp.in_ready_c%0d", c), 32'(i4.in_ready), 0);
            chk4_counts($sformatf("bp_c%0d", c), 2, 1, 1, 9);
        end
        i4.out_ready = 1'b1;
        step();
        i4.in_valid = 1'b0;
        chk("bp.take_out_valid", 32'(i4.out_valid), 0);
        chk("bp.take_in_ready", 32'(i4.in_ready), 1);
        chk4_counts("bp.cleared", 0, 0, 0, 0);
        run_frame(1, 1'b0);

        // Reset mid-frame discards the partial frame.
        drive4(frames[0].s[0]);
        step();
        drive4(frames[0].s[1]);
        step();
        rst = 1'b1;
        i4.in_valid = 1'b0;
        step();
        chk("midrst.in_ready", 32'(i4.in_ready), 1);
        chk("midrst.out_valid", 32'(i4.out_valid), 0);
        chk4_counts("midrst", 0, 0, 0, 0);
        rst = 1'b0;
        run_frame(4, 1'b0);

`ifdef CMP_FRAME_CHECK_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("err.after_rst", 32'(err4), 0);
        drive4(mk(3, 3, G));
        step();
        i4.in_valid = 1'b0;
        chk("err.set", 32'(err4), 1);
        chk("err.gt_counted", 32'(i4.gt_cnt), 1);
        step();
        step();
        chk("err.sticky_idle", 32'(err4), 1);
        for (int s = 0; s < 3; s++) begin
            drive4(mk(1, 1, E));
            step();
        end
        i4.in_valid = 1'b0;
        chk("err.frame_valid", 32'(i4.out_valid), 1);
        chk4_counts("err.frame", 1, 0, 3, 3);
        step();
        chk("err.sticky_after_take", 32'(err4), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("err.cleared_by_rst", 32'(err4), 0);
`endif

        // Gapped input on FRAME_LEN=16.
        i16.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            i16.in_valid = 1'b1;
            i16.x = 8'd1;
            i16.y = 8'd1;
            {i16.xgy, i16.xsy, i16.xey} = E;
            step();
            if (k == 7) begin
                chk("gap.mid_out_valid", 32'(i16.out_valid), 0);
                chk("gap.mid_eq", 32'(i16.eq_cnt), 8);
            end
            if (k == 15) begin
                chk("gap.out_valid", 32'(i16.out_valid), 1);
                chk("gap.eq", 32'(i16.eq_cnt), 16);
                chk("gap.gt", 32'(i16.gt_cnt), 0);
                chk("gap.lt", 32'(i16.lt_cnt), 0);
                chk("gap.xmax", 32'(i16.x_max), 1);
            end
            i16.in_valid = 1'b0;
            step();
        end
        chk("gap.after_out_valid", 32'(i16.out_valid), 0);
        chk("gap.after_in_ready", 32'(i16.in_ready), 1);

        // FRAME_LEN=1 alternates ACCUM/HOLD.
        i1.out_ready = 1'b1;
        i1.in_valid = 1'b1;
        i1.x = 8'd200;
        i1.y = 8'd100;
        {i1.xgy, i1.xsy, i1.xey} = G;
        step();
        chk("min.s1_out_valid", 32'(i1.out_valid), 1);
        chk("min.s1_in_ready", 32'(i1.in_ready), 0);
        chk("min.s1_gt", 32'(i1.gt_cnt), 1);
        chk("min.s1_lt", 32'(i1.lt_cnt), 0);
        chk("min.s1_xmax", 32'(i1.x_max), 200);
        i1.x = 8'd50;
        i1.y = 8'd60;
        {i1.xgy, i1.xsy, i1.xey} = L;
        step();
        chk("min.take_out_valid", 32'(i1.out_valid), 0);
        chk("min.take_in_ready", 32'(i1.in_ready), 1);
        step();
        i1.in_valid = 1'b0;
        chk("min.s2_out_valid", 32'(i1.out_valid), 1);
        chk("min.s2_gt", 32'(i1.gt_cnt), 0);
        chk("min.s2_lt", 32'(i1.lt_cnt), 1);
        chk("min.s2_eq", 32'(i1.eq_cnt), 0);
        chk("min.s2_xmax", 32'(i1.x_max), 50);
        step();
        chk("min.end_out_valid", 32'(i1.out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmp_frame_stats.md
# cmp_frame_stats

Downstream consumer of the 8-bit magnitude comparator `sumu4`. It takes the comparator's operand pair and `xgy`/`xsy`/`xey` flags as a valid/ready sample stream. Over frames of `FRAME_LEN` accepted samples it counts greater/less/equal outcomes and tracks the largest `x`. At each frame end it presents a registered summary on a valid/ready output.

## Interface
- `FRAME_LEN`, 16: accepted samples per frame; legal range 1..255.
- `CW`, `$clog2(FRAME_LEN+1)`: width of the count fields (derived; not overridden).
- `clk` in 1: sole clock; rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: sample present.
- `in_ready` out 1: block can accept a sample.
- `x` in 8: comparator operand x.
- `y` in 8: comparator operand y.
- `xgy` in 1: comparator flag, x > y.
- `xsy` in 1: comparator flag, x < y.
- `xey` in 1: comparator flag, x == y.
- `out_valid` out 1: frame summary present.
- `out_ready` in 1: consumer accepts the summary.
- `gt_cnt` out CW: samples in the frame with `xgy`.
- `lt_cnt` out CW: samples in the frame with `xsy`.
- `eq_cnt` out CW: samples in the frame with `xey`.
- `x_max` out 8: largest `x` accepted in the frame (unsigned).
- `err` out 1: sticky flag-consistency error; present only with `CMP_FRAME_CHECK_EN`.

## Operation
- Two-state FSM, `ACCUM` and `HOLD`; reset state is `ACCUM`.
- **ACCUM**
  - `in_ready=1`, `out_valid=0`.
  - A sample is accepted when `in_valid && in_ready`.
  - Each flag that is set increments its own counter.
  - `x_max` takes `max(x_max, x)`; the first sample of a frame loads `x` directly.
  - The sample counter increments on each accepted sample.
  - On the accept that brings the sample counter to `FRAME_LEN`, the FSM moves to `HOLD`.
- **HOLD**
  - `in_ready=0`, `out_valid=1`.
  - `gt_cnt`, `lt_cnt`, `eq_cnt` and `x_max` are stable.
  - On `out_valid && out_ready` the FSM returns to `ACCUM`. All counters, the sample counter and `x_max` clear to 0 on that edge.
- Counts are taken from the flags as given, with no correction. Malformed flag patterns (none set, or several set) still advance the sample counter, so `gt+lt+eq` may differ from `FRAME_LEN`.
- Counters cannot overflow: each is bounded by `FRAME_LEN` and `CW` holds `FRAME_LEN`.
- Reset values:
  - `in_ready=1`, `out_valid=0`.
  - `gt_cnt=lt_cnt=eq_cnt=0`, `x_max=0`, `err=0`.
  - Sample counter 0.
- A reset mid-frame or in `HOLD` discards the partial frame or pending summary with no output.

## Timing
- `in_ready` and `out_valid` are decoded from state only. Neither depends combinationally on `in_valid` or `out_ready`.
- Latency: the summary is valid the cycle after the final sample is accepted.
- Throughput:
  - One sample per cycle in `ACCUM`.
  - A frame costs `FRAME_LEN` accept cycles plus at least 1 `HOLD` cycle.
  - If `out_ready` is already high, `HOLD` lasts exactly 1 cycle.
- No input is accepted in the cycle the summary is taken. The first sample of the next frame is accepted one cycle later at the earliest.
- `FRAME_LEN=1`: every accepted sample produces a summary, so the block alternates `ACCUM`/`HOLD`.
- `out_ready` held low keeps `HOLD` indefinitely with outputs frozen. Upstream stalls.

## Configuration
- `CMP_FRAME_CHECK_EN` defined:
  - Each accepted sample is checked two ways: the flags must be one-hot, and they must match a local recomputation of `x>y`, `x<y`, `x==y`.
  - Any mismatch sets `err` on the next edge.
  - `err` clears only on `rst`.
- Not defined:
  - The `err` port and all check logic are absent.
  - The remaining behaviour is identical.

## Structure
- The shared package `cmp_pkg` holds:
  - the FSM state enum `{ACCUM, HOLD}`;
  - the operand width constant `CMP_W = 8`;
  - a `cmp_flags_t` struct `{gt, lt, eq}`, reused by `sumu4`-side logic.
- One natural sub-module, `cmp_flag_check`: the combinational recompute-and-compare used under `CMP_FRAME_CHECK_EN`. The sticky `err` register stays in the top level.
- The FSM and counters live in the top level.

## Test plan
- **Basic frame:** `FRAME_LEN=4`; samples (5,3), (2,7), (4,4), (9,1) with correct flags and `out_ready=1` → one cycle after the 4th accept, `out_valid=1`, `gt=2`, `lt=1`, `eq=1`, `x_max=9`; `in_ready=1` again 2 cycles after the 4th accept.
- **Back-pressure:** same frame with `out_ready=0` for 5 cycles → `out_valid` held and outputs unchanged; `in_ready=0` throughout; `in_valid` asserted during `HOLD` is not counted.
- **Gapped input:** `in_valid` toggled every other cycle; 16 samples of (1,1) → `eq=16`, `gt=lt=0`, `x_max=1`.
- **Reset mid-frame:** `rst` after 2 of 4 samples, then 4 samples of (0,255) → summary `lt=4`, `gt=eq=0`, `x_max=0`; earlier samples are not included.
- **Check, corrupted flag:** with `CMP_FRAME_CHECK_EN`, feed (3,3) with `xgy=1`, `xey=0` → `err=1` the next cycle and it stays 1; `gt_cnt` counts that sample.
- **Minimum frame:** `FRAME_LEN=1`; stream (200,100), (50,60) → two summaries: `gt=1`, `x_max=200`, then `lt=1`, `x_max=50`.
